// File: rtl/ds18b20_pkg.sv
// Shared types and constants for the DS18B20 temperature reader.
// Holds the scratchpad FSM states, the one-wire command set used by the
// controller sequencer, and the Dallas/Maxim CRC-8 single-bit step.
package ds18b20_pkg;

  localparam logic [7:0]  DS_CRC_POLY      = 8'h8C;
  localparam int unsigned DS_SCRATCH_BYTES = 9;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_CRC,
    S_DONE
  } ds_state_e;

  typedef enum logic [7:0] {
    OW_READ_ROM      = 8'h33,
    OW_MATCH_ROM     = 8'h55,
    OW_SKIP_ROM      = 8'hCC,
    OW_SEARCH_ROM    = 8'hF0,
    OW_CONVERT_T     = 8'h44,
    OW_WRITE_SCRATCH = 8'h4E,
    OW_READ_SCRATCH  = 8'hBE,
    OW_COPY_SCRATCH  = 8'h48
  } ds_cmd_e;

  // One LSB-first bit of the reflected Dallas CRC-8.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
    logic fb;
    fb        = crc[0] ^ din;
    crc8_step = {1'b0, crc[7:1]} ^ (fb ? DS_CRC_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/crc8_dallas.sv
// Bit-serial Dallas/Maxim CRC-8 register (reflected poly 0x8C, init 0x00).
// Compiled only when DS18B20_SCRATCH_CRC_EN is defined; otherwise the
// scratchpad block carries no CRC hardware at all.
`ifdef DS18B20_SCRATCH_CRC_EN
module crc8_dallas
  import ds18b20_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clear_i,
  input  logic       shift_i,
  input  logic       bit_i,
  output logic [7:0] crc_o
);

  logic [7:0] crc_q, crc_d;

  // Clear has priority so a restart mid-shift begins from a clean register.
  always_comb begin
    crc_d = crc_q;
    if (clear_i) begin
      crc_d = '0;
    end else if (shift_i) begin
      crc_d = crc8_step(crc_q, bit_i);
    end
  end

  // CRC state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule
`endif

// File: rtl/ds18b20_scratchpad.sv
// DS18B20 scratchpad collector: gathers the 9 read-scratchpad bytes, runs
// each byte through an 8-cycle serial CRC slot, and on a good frame
// publishes raw temperature, integer degrees and hot/cold alarms.
// Optional feature macro: DS18B20_SCRATCH_CRC_EN (CRC check enabled).
// Without it o_crc_ok is tied high and every completed frame publishes;
// the 8-cycle slot per byte is kept so timing is identical.
module ds18b20_scratchpad
  import ds18b20_pkg::*;
#(
  parameter logic signed [15:0] TH_HI = 16'sd480,
  parameter logic signed [15:0] TH_LO = 16'sd320
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_byte_vld,
  input  logic [7:0]  i_byte,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_crc_ok,
  output logic        o_ovf,
  output logic [3:0]  o_byte_cnt,
  output logic [15:0] o_temp,
  output logic [7:0]  o_temp_c,
  output logic        o_hot,
  output logic        o_cold
);

  localparam logic [3:0] LAST_CNT = 4'(DS_SCRATCH_BYTES);

  ds_state_e state_q, state_d;

  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  byte0_q, byte0_d;
  logic [7:0]  byte1_q, byte1_d;
  logic        ovf_q, ovf_d;
  logic [15:0] temp_q, temp_d;
  logic [7:0]  tc_q, tc_d;
  logic        hot_q, hot_d;
  logic        cold_q, cold_d;

  logic accept, drop, shift_en, publish, pass;
  logic signed [15:0] raw, raw_sr;

  assign raw    = {byte1_q, byte0_q};
  assign raw_sr = raw >>> 4;

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: start restarts from any state.
  always_comb begin
    state_d = state_q;
    if (i_start) begin
      state_d = S_COLLECT;
    end else begin
      case (state_q)
        S_IDLE:    state_d = S_IDLE;
        S_COLLECT: if (i_byte_vld) state_d = S_CRC;
        S_CRC:     if (bit_q == 3'd7) state_d = (cnt_q == LAST_CNT) ? S_DONE : S_COLLECT;
        S_DONE:    state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // FSM outputs and datapath strobes.
  always_comb begin
    o_busy   = (state_q != S_IDLE);
    o_done   = (state_q == S_DONE);
    accept   = !i_start && (state_q == S_COLLECT) && i_byte_vld;
    drop     = !i_start && (state_q == S_CRC) && i_byte_vld;
    shift_en = (state_q == S_CRC);
    publish  = (state_q == S_CRC) && (state_d == S_DONE);
  end

`ifdef DS18B20_SCRATCH_CRC_EN
  logic [7:0] sh_q, sh_d;
  logic [7:0] crc_w;
  logic       crc_ok_q, crc_ok_d;

  crc8_dallas u_crc (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .clear_i (i_start),
    .shift_i (shift_en),
    .bit_i   (sh_q[0]),
    .crc_o   (crc_w)
  );

  // The registered CRC lags by the bit being shifted now; folding that bit
  // in here lets the residue verdict land in the same cycle as o_done.
  assign pass = (crc8_step(crc_w, sh_q[0]) == 8'h00);

  // Byte shifter feeding the CRC LSB-first, and the pass flag.
  always_comb begin
    sh_d     = sh_q;
    crc_ok_d = crc_ok_q;
    if (accept) begin
      sh_d = i_byte;
    end else if (shift_en) begin
      sh_d = {1'b0, sh_q[7:1]};
    end
    if (publish) begin
      crc_ok_d = pass;
    end
  end

  // CRC-side registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sh_q     <= '0;
      crc_ok_q <= 1'b0;
    end else begin
      sh_q     <= sh_d;
      crc_ok_q <= crc_ok_d;
    end
  end

  assign o_crc_ok = crc_ok_q;
`else
  assign pass     = 1'b1;
  assign o_crc_ok = 1'b1;
`endif

  // Datapath next state: byte count, slot counter, stored bytes, overflow
  // and the published temperature group.
  always_comb begin
    cnt_d   = cnt_q;
    bit_d   = '0;
    byte0_d = byte0_q;
    byte1_d = byte1_q;
    ovf_d   = ovf_q;
    temp_d  = temp_q;
    tc_d    = tc_q;
    hot_d   = hot_q;
    cold_d  = cold_q;
    if (state_q == S_CRC) begin
      bit_d = bit_q + 3'd1;
    end
    if (i_start) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else begin
      if (accept) begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd0) byte0_d = i_byte;
        if (cnt_q == 4'd1) byte1_d = i_byte;
      end
      if (drop) begin
        ovf_d = 1'b1;
      end
    end
    if (publish && pass) begin
      temp_d = raw;
      tc_d   = raw_sr[7:0];
      hot_d  = (raw >= TH_HI);
      cold_d = (raw <= TH_LO);
    end
  end

  // Datapath registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q   <= '0;
      bit_q   <= '0;
      byte0_q <= '0;
      byte1_q <= '0;
      ovf_q   <= 1'b0;
      temp_q  <= '0;
      tc_q    <= '0;
      hot_q   <= 1'b0;
      cold_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte0_q <= byte0_d;
      byte1_q <= byte1_d;
      ovf_q   <= ovf_d;
      temp_q  <= temp_d;
      tc_q    <= tc_d;
      hot_q   <= hot_d;
      cold_q  <= cold_d;
    end
  end

  assign o_ovf      = ovf_q;
  assign o_byte_cnt = cnt_q;
  assign o_temp     = temp_q;
  assign o_temp_c   = tc_q;
  assign o_hot      = hot_q;
  assign o_cold     = cold_q;

endmodule

// File: tb/tb_ds18b20_scratchpad.sv
// Self-checking bench for ds18b20_scratchpad: a table of known frames,
// hand-written corner sequences and randomized frames, all compared every
// cycle against a timing-window reference model.
`timescale 1ns/1ps
module tb_ds18b20_scratchpad;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        vld = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        o_busy, o_done, o_crc_ok, o_ovf, o_hot, o_cold;
  logic [3:0]  o_byte_cnt;
  logic [15:0] o_temp;
  logic [7:0]  o_temp_c;

  always #5 clk = ~clk;

  ds18b20_scratchpad #(.TH_HI(16'sd480), .TH_LO(16'sd320)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .i_byte_vld (vld),
    .i_byte     (byte_in),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_crc_ok   (o_crc_ok),
    .o_ovf      (o_ovf),
    .o_byte_cnt (o_byte_cnt),
    .o_temp     (o_temp),
    .o_temp_c   (o_temp_c),
    .o_hot      (o_hot),
    .o_cold     (o_cold)
  );

`ifdef DS18B20_SCRATCH_CRC_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  always @(negedge clk) if (o_done === 1'b1) done_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int          cyc;
  bit          m_act;
  int          m_cnt;
  bit          m_ovf;
  logic [7:0]  m_b[$];
  int          m_shift_end;
  int          m_done_cyc;
  logic [15:0] m_temp;
  logic [7:0]  m_tc;
  bit          m_hot, m_cold, m_crc_ok;

  function automatic logic [7:0] crc_bytes(input logic [71:0] fr, input int n);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 8; j++) begin
        logic fb;
        fb = c[0] ^ fr[8*i+j];
        c  = c >> 1;
        if (fb) c = c ^ 8'h8C;
      end
    end
    return c;
  endfunction

  function automatic int floor16(input int t);
    if (t >= 0) return t / 16;
    return -((-t + 15) / 16);
  endfunction

  task automatic model_reset();
    m_act = 0; m_cnt = 0; m_ovf = 0; m_b.delete();
    m_shift_end = -100; m_done_cyc = -100;
    m_temp = '0; m_tc = '0; m_hot = 0; m_cold = 0;
    m_crc_ok = !CRC_EN;
  endtask

  task automatic model_publish();
    logic [71:0] fr;
    logic [15:0] t16;
    int          t;
    bit          pass;
    fr = '0;
    foreach (m_b[i]) fr[8*i +: 8] = m_b[i];
    pass = (crc_bytes(fr, 9) == 8'h00);
    if (!CRC_EN) pass = 1;
    m_crc_ok = pass;
    if (pass) begin
      t16    = fr[15:0];
      t      = int'($signed(t16));
      m_temp = t16;
      m_tc   = 8'(floor16(t));
      m_hot  = (t >= 480);
      m_cold = (t <= 320);
    end
  endtask

  // Advance the model across one clock edge given that cycle's inputs.
  task automatic model_update(input bit st, input bit v, input logic [7:0] d);
    if (st) begin
      m_act = 1; m_cnt = 0; m_ovf = 0; m_b.delete();
      m_shift_end = -100; m_done_cyc = -100;
    end else if (m_act) begin
      if (v) begin
        if (cyc <= m_shift_end) m_ovf = 1;
        else if (cyc != m_done_cyc && m_cnt < 9) begin
          m_b.push_back(d);
          m_cnt++;
          m_shift_end = cyc + 8;
          if (m_cnt == 9) m_done_cyc = cyc + 9;
        end
      end
      if (cyc == m_done_cyc) m_act = 0;
    end
    cyc++;
    if (cyc == m_done_cyc) model_publish();
  endtask

  task automatic check_all();
    chk($sformatf("busy@%0d", cyc),   32'(o_busy),     32'(m_act));
    chk($sformatf("done@%0d", cyc),   32'(o_done),     32'(cyc == m_done_cyc));
    chk($sformatf("cnt@%0d", cyc),    32'(o_byte_cnt), 32'(m_cnt));
    chk($sformatf("ovf@%0d", cyc),    32'(o_ovf),      32'(m_ovf));
    chk($sformatf("crc_ok@%0d", cyc), 32'(o_crc_ok),   32'(m_crc_ok));
    chk($sformatf("temp@%0d", cyc),   32'(o_temp),     32'(m_temp));
    chk($sformatf("temp_c@%0d", cyc), 32'(o_temp_c),   32'(m_tc));
    chk($sformatf("hot@%0d", cyc),    32'(o_hot),      32'(m_hot));
    chk($sformatf("cold@%0d", cyc),   32'(o_cold),     32'(m_cold));
  endtask

  task automatic step(input bit st, input bit v, input logic [7:0] d);
    start = st; vld = v; byte_in = d;
    @(posedge clk);
    model_update(st, v, d);
    #1;
    start = 1'b0; vld = 1'b0;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 8'h00);
  endtask

  // Send bytes 0..n-1 of a frame, 12 cycles apart.
  task automatic send(input logic [71:0] fr, input int n);
    for (int i = 0; i < n; i++) begin
      step(0, 1, fr[8*i +: 8]);
      if (i != n - 1) idle(11);
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [63:0] first8;
    logic [7:0]  crc;
    bit          calc_crc;
    logic [15:0] e_temp;
    logic [7:0]  e_tc;
    bit          e_hot, e_cold, e_ok;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [71:0] fr;
    int          base;
    bit          seen;

    vecs[0] = '{64'h10_0C_FF_7F_46_4B_05_50, 8'h1C, 0, 16'h0550, 8'd85, 1, 0, 1};
    vecs[1] = '{64'h10_0C_FF_7F_46_4B_01_91, 8'h00, 1, 16'h0191, 8'd25, 0, 0, 1};
    vecs[2] = '{64'h10_0C_FF_7F_46_4B_FF_5E, 8'h00, 1, 16'hFF5E, 8'hF5, 0, 1, 1};
    if (CRC_EN)
      vecs[3] = '{64'h10_0C_FF_7F_46_4B_05_50, 8'h1D, 0, 16'hFF5E, 8'hF5, 0, 1, 0};
    else
      vecs[3] = '{64'h10_0C_FF_7F_46_4B_05_50, 8'h1D, 0, 16'h0550, 8'd85, 1, 0, 1};
    vecs[4] = '{64'h10_0C_FF_7F_46_4B_01_E0, 8'h00, 1, 16'h01E0, 8'd30, 1, 0, 1};
    vecs[5] = '{64'h10_0C_FF_7F_46_4B_01_DF, 8'h00, 1, 16'h01DF, 8'd29, 0, 0, 1};
    vecs[6] = '{64'h10_0C_FF_7F_46_4B_01_40, 8'h00, 1, 16'h0140, 8'd20, 0, 1, 1};
    vecs[7] = '{64'h10_0C_FF_7F_46_4B_01_41, 8'h00, 1, 16'h0141, 8'd20, 0, 0, 1};

    // Reset state
    cyc = 0;
    model_reset();
    #1 rst_n = 1'b0;
    #2 check_all();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Table-driven frames
    for (int v = 0; v < 8; v++) begin
      fr = {8'h00, vecs[v].first8};
      fr[71:64] = vecs[v].calc_crc ? crc_bytes(fr, 8) : vecs[v].crc;
      step(1, 0, 8'h00);
      send(fr, 9);
      seen = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
        step(0, 0, 8'h00);
        if (o_done === 1'b1) seen = 1;
      end
      chk($sformatf("v%0d done_seen", v), 32'(seen), 32'd1);
      chk($sformatf("v%0d crc_ok", v), 32'(o_crc_ok), 32'(vecs[v].e_ok));
      chk($sformatf("v%0d temp", v),   32'(o_temp),   32'(vecs[v].e_temp));
      chk($sformatf("v%0d temp_c", v), 32'(o_temp_c), 32'(vecs[v].e_tc));
      chk($sformatf("v%0d hot", v),    32'(o_hot),    32'(vecs[v].e_hot));
      chk($sformatf("v%0d cold", v),   32'(o_cold),   32'(vecs[v].e_cold));
      step(0, 0, 8'h00);
      chk($sformatf("v%0d busy_fall", v), 32'(o_busy), 32'd0);
    end

    // Overflow: second strobe 4 cycles after the first
    fr = {8'h1C, 64'h10_0C_FF_7F_46_4B_05_50};
    base = done_cnt;
    step(1, 0, 8'h00);
    step(0, 1, 8'h50);
    idle(3);
    step(0, 1, 8'h05);
    chk("ovf_set", 32'(o_ovf), 32'd1);
    chk("ovf_cnt", 32'(o_byte_cnt), 32'd1);
    idle(11);
    send(fr >> 8, 7);
    idle(14);
    chk("ovf_no_done", 32'(done_cnt - base), 32'd0);
    chk("ovf_cnt8", 32'(o_byte_cnt), 32'd8);
    chk("ovf_sticky", 32'(o_ovf), 32'd1);
    step(1, 0, 8'h00);
    chk("ovf_cleared", 32'(o_ovf), 32'd0);

    // Start and strobe in the same cycle: start wins
    step(1, 1, 8'hAA);
    chk("startwin_cnt", 32'(o_byte_cnt), 32'd0);
    chk("startwin_ovf", 32'(o_ovf), 32'd0);

    // Abort after 5 bytes, then a full valid frame
    base = done_cnt;
    fr = {8'h00, vecs[1].first8};
    fr[71:64] = crc_bytes(fr, 8);
    step(1, 0, 8'h00);
    send(fr, 5);
    idle(3);
    step(1, 0, 8'h00);
    send(fr, 9);
    idle(14);
    chk("abort_single_done", 32'(done_cnt - base), 32'd1);
    chk("abort_temp", 32'(o_temp), 32'h0191);

    // Asynchronous reset in the middle of a CRC slot
    step(1, 0, 8'h00);
    step(0, 1, 8'h11);
    idle(2);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_temp", 32'(o_temp), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // Randomized frames
    for (int f = 0; f < 40; f++) begin
      int   t;
      int   gap;
      fr = '0;
      t = int'($urandom_range(0, 1400)) - 500;
      fr[15:0] = 16'(t);
      for (int i = 2; i < 8; i++) fr[8*i +: 8] = 8'($urandom);
      fr[71:64] = ($urandom_range(0, 3) != 0) ? crc_bytes(fr, 8) : 8'($urandom);
      if ($urandom_range(0, 7) == 0) step(1, 1, 8'($urandom));
      else step(1, 0, 8'h00);
      for (int i = 0; i < 9; i++) begin
        gap = ($urandom_range(0, 11) == 0) ? int'($urandom_range(1, 7)) : int'($urandom_range(8, 12));
        idle(gap);
        if ($urandom_range(0, 39) == 0) step(1, 0, 8'h00);
        step(0, 1, fr[8*i +: 8]);
      end
      idle(int'($urandom_range(9, 14)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
